gppcu_sreg_update: RTL and testbench

Producer side of the GPPCU status register. Derives Z/N/C/V flags from each retiring ALU operation, applies a per-op update mask and holds the architectural SREG. The SREG drives the condition check stage through oSREG. Adds a small shadow stack so SREG can be saved and restored around interrupts and calls.

---
 rtl/gppcu_sreg_update_pkg.sv | 23 ++
 rtl/gppcu_sreg_flaggen.sv | 60 ++++++
 rtl/gppcu_sreg_update.sv | 145 ++++++++++++++
 tb/tb_gppcu_sreg_update.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gppcu_sreg_update_pkg.sv
// gppcu_sreg_update_pkg
//   Shared definitions for the GPPCU status-register producer.
//   - SREG bit indices (Z, N, C, V, S) and widths.
//   - ALU op-class encodings consumed by the flag generator.
package gppcu_sreg_update_pkg;

  localparam int SREG_W = 5;  // architectural SREG width
  localparam int FLAG_W = 4;  // ALU-derived flags {V,C,N,Z}

  localparam int SREG_Z = 0;
  localparam int SREG_N = 1;
  localparam int SREG_C = 2;
  localparam int SREG_V = 3;
  localparam int SREG_S = 4;

  typedef enum logic [1:0] {
    OPCLS_ADD   = 2'd0,
    OPCLS_SUB   = 2'd1,
    OPCLS_LOGIC = 2'd2,
    OPCLS_SHIFT = 2'd3
  } opcls_e;

endpackage

// File: rtl/gppcu_sreg_flaggen.sv
// gppcu_sreg_flaggen
//   Purely combinational Z/N/C/V derivation for one ALU result. Kept
//   stand-alone so the ALU can reuse it for flag forwarding.
// Ports:
//   i_opcls  op class (ADD/SUB/LOGIC/SHIFT)
//   i_opa    operand A
//   i_opb    operand B
//   i_res    ALU result
//   i_cout   adder carry-out, or last bit shifted out for SHIFT
//   o_flags  {V,C,N,Z}, indexed by the SREG_* bit positions
module gppcu_sreg_flaggen
  import gppcu_sreg_update_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  opcls_e              i_opcls,
  input  logic [DATA_W-1:0]   i_opa,
  input  logic [DATA_W-1:0]   i_opb,
  input  logic [DATA_W-1:0]   i_res,
  input  logic                i_cout,
  output logic [FLAG_W-1:0]   o_flags
);

  logic w_a_msb;
  logic w_b_msb;
  logic w_r_msb;

  assign w_a_msb = i_opa[DATA_W-1];
  assign w_b_msb = i_opb[DATA_W-1];
  assign w_r_msb = i_res[DATA_W-1];

  // Overflow only needs operand sign bits; the low bits are folded here so
  // the full-width operand ports (kept for forwarding reuse) don't dangle.
  logic w_unused_opab;
  assign w_unused_opab = ^{i_opa[DATA_W-2:0], i_opb[DATA_W-2:0]};

  always_comb begin
    o_flags         = '0;
    o_flags[SREG_Z] = (i_res == '0);
    o_flags[SREG_N] = w_r_msb;
    unique case (i_opcls)
      OPCLS_ADD: begin
        o_flags[SREG_C] = i_cout;
        o_flags[SREG_V] = (w_a_msb == w_b_msb) && (w_r_msb != w_a_msb);
      end
      OPCLS_SUB: begin
        // Adder computes A + ~B + 1, so borrow is the inverted carry.
        o_flags[SREG_C] = ~i_cout;
        o_flags[SREG_V] = (w_a_msb != w_b_msb) && (w_r_msb != w_a_msb);
      end
      OPCLS_SHIFT: begin
        o_flags[SREG_C] = i_cout;
      end
      default: begin
        // LOGIC: C and V forced low, already cleared by the default.
      end
    endcase
  end

endmodule

// File: rtl/gppcu_sreg_update.sv
// gppcu_sreg_update
//   Producer side of the GPPCU status register: captures masked ALU flags
//   on each retiring op, supports explicit SREG writes, and keeps a small
//   shadow stack for save/restore around interrupts and calls.
//   Optional build macro: GPPCU_SREG_STICKY_OVF_EN -- when defined, any
//   retiring op that updates V with V=1 also sets the sticky SREG_S bit.
// Ports:
//   iCLK, iRST       clock (rising edge), async active-high reset
//   iVALID           ALU op retiring; masked flags captured
//   iOPCLS           op class
//   iOPA/iOPB/iRES   operands and result
//   iCOUT            carry-out / last shifted-out bit
//   iMASK            flag update enables {V,C,N,Z}
//   iWR/iWDATA       explicit SREG write (highest priority)
//   iPUSH/iPOP       shadow stack push/pop (both = swap when non-empty)
//   oSREG            architectural SREG
//   oSTK_EMPTY/FULL  stack occupancy
//   oSTK_ERR         sticky overflow/underflow indicator
module gppcu_sreg_update
  import gppcu_sreg_update_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int STACK_DEPTH = 4
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iVALID,
  input  logic [1:0]          iOPCLS,
  input  logic [DATA_W-1:0]   iOPA,
  input  logic [DATA_W-1:0]   iOPB,
  input  logic [DATA_W-1:0]   iRES,
  input  logic                iCOUT,
  input  logic [FLAG_W-1:0]   iMASK,
  input  logic                iWR,
  input  logic [SREG_W-1:0]   iWDATA,
  input  logic                iPUSH,
  input  logic                iPOP,
  output logic [SREG_W-1:0]   oSREG,
  output logic                oSTK_EMPTY,
  output logic                oSTK_FULL,
  output logic                oSTK_ERR
);

  localparam int AW = $clog2(STACK_DEPTH);
  localparam int CW = AW + 1;  // count must reach STACK_DEPTH itself

  logic [SREG_W-1:0] r_sreg;
  logic [CW-1:0]     r_cnt;
  logic              r_err;
  logic [SREG_W-1:0] r_stk [STACK_DEPTH];

  logic [FLAG_W-1:0] w_flags;
  logic              w_empty;
  logic              w_full;
  logic [AW-1:0]     w_top_idx;
  logic [AW-1:0]     w_push_idx;
  logic [SREG_W-1:0] w_top;
  logic [SREG_W-1:0] w_sreg_nxt;
  logic [CW-1:0]     w_cnt_nxt;
  logic              w_err_nxt;
  logic              w_stk_we;
  logic [AW-1:0]     w_stk_idx;

  gppcu_sreg_flaggen #(
    .DATA_W (DATA_W)
  ) u_flaggen (
    .i_opcls (opcls_e'(iOPCLS)),
    .i_opa   (iOPA),
    .i_opb   (iOPB),
    .i_res   (iRES),
    .i_cout  (iCOUT),
    .o_flags (w_flags)
  );

  assign w_empty    = (r_cnt == '0);
  assign w_full     = (r_cnt == CW'(STACK_DEPTH));
  assign w_top_idx  = AW'(r_cnt - 1'b1);
  assign w_push_idx = AW'(r_cnt);
  assign w_top      = r_stk[w_top_idx];

  // Next-state: stack op first, then masked flag merge, then iWR on top.
  always_comb begin
    w_sreg_nxt = r_sreg;
    w_cnt_nxt  = r_cnt;
    w_err_nxt  = r_err;
    w_stk_we   = 1'b0;
    w_stk_idx  = w_push_idx;

    if (iPUSH && iPOP && !w_empty) begin
      // Swap: old SREG replaces the top entry, depth unchanged.
      w_sreg_nxt = w_top;
      w_stk_we   = 1'b1;
      w_stk_idx  = w_top_idx;
    end else if (iPUSH) begin
      // Also covers push+pop on an empty stack (cannot be full here).
      if (w_full) begin
        w_err_nxt = 1'b1;
      end else begin
        w_stk_we  = 1'b1;
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end else if (iPOP) begin
      if (w_empty) begin
        w_err_nxt = 1'b1;
      end else begin
        w_sreg_nxt = w_top;
        w_cnt_nxt  = r_cnt - 1'b1;
      end
    end

    if (iVALID) begin
      for (int i = 0; i < FLAG_W; i++) begin
        if (iMASK[i]) w_sreg_nxt[i] = w_flags[i];
      end
`ifdef GPPCU_SREG_STICKY_OVF_EN
      if (iMASK[SREG_V] && w_flags[SREG_V]) w_sreg_nxt[SREG_S] = 1'b1;
`endif
    end

    if (iWR) w_sreg_nxt = iWDATA;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_sreg <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_sreg <= w_sreg_nxt;
      r_cnt  <= w_cnt_nxt;
      r_err  <= w_err_nxt;
    end
  end

  // Stack storage carries no reset; occupancy is tracked by r_cnt alone.
  always_ff @(posedge iCLK) begin
    if (w_stk_we) r_stk[w_stk_idx] <= r_sreg;
  end

  assign oSREG      = r_sreg;
  assign oSTK_EMPTY = w_empty;
  assign oSTK_FULL  = w_full;
  assign oSTK_ERR   = r_err;

endmodule

// File: tb/tb_gppcu_sreg_update.sv
module tb_gppcu_sreg_update;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          iCLK = 1'b0;
  logic          iRST;
  logic          iVALID;
  logic [1:0]    iOPCLS;
  logic [DW-1:0] iOPA, iOPB, iRES;
  logic          iCOUT;
  logic [3:0]    iMASK;
  logic          iWR;
  logic [4:0]    iWDATA;
  logic          iPUSH, iPOP;
  logic [4:0]    oSREG;
  logic          oSTK_EMPTY, oSTK_FULL, oSTK_ERR;

  gppcu_sreg_update #(.DATA_W(DW), .STACK_DEPTH(DEPTH)) dut (
    .iCLK(iCLK), .iRST(iRST), .iVALID(iVALID), .iOPCLS(iOPCLS),
    .iOPA(iOPA), .iOPB(iOPB), .iRES(iRES), .iCOUT(iCOUT), .iMASK(iMASK),
    .iWR(iWR), .iWDATA(iWDATA), .iPUSH(iPUSH), .iPOP(iPOP),
    .oSREG(oSREG), .oSTK_EMPTY(oSTK_EMPTY), .oSTK_FULL(oSTK_FULL),
    .oSTK_ERR(oSTK_ERR)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [4:0] sreg;
    logic       empty;
    logic       full;
    logic       err;
    int         tag;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   step_no = 0;

  // Reference model state: SREG value, stack as a LIFO queue, sticky error.
  logic [4:0] m_sreg;
  logic [4:0] m_stk[$];
  logic       m_err;

  localparam logic [1:0] C_ADD = 2'd0, C_SUB = 2'd1, C_LOGIC = 2'd2, C_SHIFT = 2'd3;

  function automatic logic [3:0] ref_flags(input logic [1:0] cls, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b, input logic [DW-1:0] r,
                                           input logic cout);
    longint sa, sb, s;
    longint unsigned ua, ub;
    logic z, n, c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    z = (r == 0);
    n = ($signed(r) < 0);
    c = 1'b0;
    v = 1'b0;
    case (cls)
      C_ADD: begin
        s = sa + sb;
        c = (ua + ub) > 64'hFFFF_FFFF;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      C_SUB: begin
        s = sa - sb;
        c = (ua < ub);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      C_SHIFT: c = cout;
      default: ;
    endcase
    return {v, c, n, z};
  endfunction

  task automatic model_reset();
    m_sreg = '0;
    m_stk.delete();
    m_err = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [1:0] cls, input logic [DW-1:0] a,
                            input logic [DW-1:0] b, input logic [DW-1:0] r, input logic cout,
                            input logic [3:0] mask, input logic wr, input logic [4:0] wd,
                            input logic push, input logic pop);
    logic [4:0] nx;
    logic [4:0] tmp;
    logic [3:0] f;
    nx = m_sreg;
    if (push && pop && m_stk.size() > 0) begin
      tmp = m_stk.pop_back();
      m_stk.push_back(m_sreg);
      nx = tmp;
    end else if (push) begin
      if (m_stk.size() == DEPTH) m_err = 1'b1;
      else m_stk.push_back(m_sreg);
    end else if (pop) begin
      if (m_stk.size() == 0) m_err = 1'b1;
      else nx = m_stk.pop_back();
    end
    if (v) begin
      f = ref_flags(cls, a, b, r, cout);
      for (int i = 0; i < 4; i++) if (mask[i]) nx[i] = f[i];
`ifdef GPPCU_SREG_STICKY_OVF_EN
      if (mask[3] && f[3]) nx[4] = 1'b1;
`endif
    end
    if (wr) nx = wd;
    m_sreg = nx;
  endtask

  task automatic idle_inputs();
    iVALID = 0; iOPCLS = 0; iOPA = 0; iOPB = 0; iRES = 0; iCOUT = 0;
    iMASK = 0; iWR = 0; iWDATA = 0; iPUSH = 0; iPOP = 0;
  endtask

  task automatic apply(input logic v, input logic [1:0] cls, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [DW-1:0] r, input logic cout,
                       input logic [3:0] mask, input logic wr, input logic [4:0] wd,
                       input logic push, input logic pop);
    exp_t e;
    iVALID = v; iOPCLS = cls; iOPA = a; iOPB = b; iRES = r; iCOUT = cout;
    iMASK = mask; iWR = wr; iWDATA = wd; iPUSH = push; iPOP = pop;
    model_step(v, cls, a, b, r, cout, mask, wr, wd, push, pop);
    e.sreg  = m_sreg;
    e.empty = (m_stk.size() == 0);
    e.full  = (m_stk.size() == DEPTH);
    e.err   = m_err;
    e.tag   = step_no;
    step_no++;
    q.push_back(e);
    @(posedge iCLK);
    @(negedge iCLK);
    idle_inputs();
  endtask

  task automatic alu(input logic [1:0] cls, input logic [DW-1:0] a, input logic [DW-1:0] b,
                     input logic [DW-1:0] r, input logic cout, input logic [3:0] mask);
    apply(1'b1, cls, a, b, r, cout, mask, 1'b0, 5'h0, 1'b0, 1'b0);
  endtask

  task automatic stk(input logic wr, input logic [4:0] wd, input logic push, input logic pop);
    apply(1'b0, C_LOGIC, '0, '0, '0, 1'b0, 4'h0, wr, wd, push, pop);
  endtask

  task automatic direct_check(input string name, input logic [4:0] s, input logic em,
                              input logic fu, input logic er);
    vectors++;
    if (oSREG !== s || oSTK_EMPTY !== em || oSTK_FULL !== fu || oSTK_ERR !== er) begin
      miscompares++;
      $display("FAIL %s: got sreg=%h empty=%b full=%b err=%b, want sreg=%h empty=%b full=%b err=%b",
               name, oSREG, oSTK_EMPTY, oSTK_FULL, oSTK_ERR, s, em, fu, er);
    end
  endtask

  // Monitor: outputs settle after each edge; compare against queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge iCLK);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (oSREG !== e.sreg || oSTK_EMPTY !== e.empty || oSTK_FULL !== e.full ||
            oSTK_ERR !== e.err) begin
          miscompares++;
          $display("FAIL step%0d: got sreg=%h empty=%b full=%b err=%b, want sreg=%h empty=%b full=%b err=%b",
                   e.tag, oSREG, oSTK_EMPTY, oSTK_FULL, oSTK_ERR,
                   e.sreg, e.empty, e.full, e.err);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1);
  end

  task automatic rand_op();
    logic [1:0]    cls;
    logic [DW-1:0] a, b, r;
    logic          cout;
    logic [32:0]   sum;
    int            sh;
    int            sel;
    cls  = 2'($urandom_range(0, 3));
    a    = $urandom;
    b    = ($urandom_range(0, 7) == 0) ? a : $urandom;
    cout = 1'b0;
    r    = '0;
    case (cls)
      C_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        r = sum[31:0];
        cout = sum[32];
      end
      C_SUB: begin
        r = a - b;
        cout = (a >= b);
      end
      C_LOGIC: begin
        sel = $urandom_range(0, 3);
        r = (sel == 0) ? (a & b) : (sel == 1) ? (a | b) : (sel == 2) ? (a ^ b) : '0;
      end
      default: begin
        sh = $urandom_range(1, 31);
        r = a << sh;
        cout = a[32 - sh];
      end
    endcase
    apply(($urandom_range(0, 3) != 0), cls, a, b, r, cout, 4'($urandom),
          ($urandom_range(0, 9) == 0), 5'($urandom),
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
  endtask

  initial begin
    idle_inputs();
    iRST = 1'b1;
    model_reset();
    repeat (3) @(negedge iCLK);
    direct_check("reset_initial", 5'h00, 1'b1, 1'b0, 1'b0);
    iRST = 1'b0;

    // Overflowing ADD: V=1 C=0 N=1 Z=0, then a clean LOGIC op.
    alu(C_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 4'hF);
    alu(C_LOGIC, 32'h3, 32'h1, 32'h1, 1'b0, 4'hF);
    // SUB 5-5 and 3-5.
    alu(C_SUB, 32'd5, 32'd5, 32'd0, 1'b1, 4'hF);
    alu(C_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 4'hF);
    // neg+neg -> positive: C=1 V=1, then Z-only LOGIC retains C,V.
    alu(C_ADD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, 4'hF);
    alu(C_LOGIC, 32'h0, 32'h0, 32'h0, 1'b0, 4'b0001);
    // Empty mask: no change.
    alu(C_ADD, 32'h1, 32'h1, 32'h2, 1'b0, 4'h0);
    alu(C_SHIFT, 32'h8000_0001, 32'h1, 32'h0000_0002, 1'b1, 4'hF);

    // Fill the stack with distinct values, overflow, then drain LIFO and underflow.
    stk(1'b1, 5'h11, 1'b0, 1'b0);
    stk(1'b1, 5'h12, 1'b1, 1'b0);
    stk(1'b1, 5'h13, 1'b1, 1'b0);
    stk(1'b1, 5'h14, 1'b1, 1'b0);
    stk(1'b0, 5'h00, 1'b1, 1'b0);
    stk(1'b0, 5'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) stk(1'b0, 5'h00, 1'b0, 1'b1);

    // Pop + flag update + write in one cycle: write wins, stack shrinks.
    stk(1'b1, 5'h03, 1'b1, 1'b0);
    apply(1'b1, C_LOGIC, '0, '0, '0, 1'b0, 4'b0001, 1'b1, 5'h0A, 1'b0, 1'b1);
    // Swap with one entry, then pop the swapped-in value.
    stk(1'b1, 5'h05, 1'b0, 1'b0);
    stk(1'b1, 5'h07, 1'b1, 1'b0);
    stk(1'b0, 5'h00, 1'b1, 1'b1);
    stk(1'b0, 5'h00, 1'b0, 1'b1);
    // Push+pop on empty acts as push.
    stk(1'b0, 5'h00, 1'b1, 1'b1);
    stk(1'b0, 5'h00, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a cycle with an op in flight.
    stk(1'b0, 5'h00, 1'b1, 1'b0);
    iVALID = 1; iOPCLS = C_ADD; iOPA = 32'h7FFF_FFFF; iOPB = 32'h1;
    iRES = 32'h8000_0000; iMASK = 4'hF; iWR = 1; iWDATA = 5'h1F; iPUSH = 1;
    #2;
    iRST = 1'b1;
    #1;
    direct_check("reset_async", 5'h00, 1'b1, 1'b0, 1'b0);
    @(posedge iCLK);
    #1;
    direct_check("reset_held", 5'h00, 1'b1, 1'b0, 1'b0);
    @(negedge iCLK);
    idle_inputs();
    iRST = 1'b0;
    model_reset();

    alu(C_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 4'hF);
    alu(C_LOGIC, 32'h5, 32'h5, 32'h5, 1'b0, 4'hF);

    for (int n = 0; n < 400; n++) rand_op();

    repeat (3) @(negedge iCLK);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
